// File: rtl/nsa_pkg.sv
// Shared types and helpers for the nibble-serial adder.
package nsa_pkg;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    localparam int unsigned NIBBLE_W = 4;

    // Carry out of a nibble group, given its group propagate/generate and carry in.
    function automatic logic nibble_carry(input logic p, input logic g, input logic c);
        return g | (p & c);
    endfunction

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit carry-lookahead slice: sum plus group propagate/generate.
module cla_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       p,
    output logic       g
);

    logic [3:0] pb;
    logic [3:0] gb;
    logic [3:0] c;

    // Per-bit propagate/generate, lookahead carries, and group terms.
    always_comb begin
        pb   = a ^ b;
        gb   = a & b;
        c[0] = c_in;
        c[1] = gb[0] | (pb[0] & c_in);
        c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & c_in);
        c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
             | (pb[2] & pb[1] & pb[0] & c_in);
        s    = pb ^ c;
        p    = &pb;
        g    = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
             | (pb[3] & pb[2] & pb[1] & gb[0]);
    end

endmodule

// File: rtl/nibble_serial_adder16.sv
// Multi-cycle adder: one nibble per clock through a single lookahead slice, LSB first.
// Optional subtract mode (Sub port, A-B in two's complement) under NSA_SUBTRACT_EN.
module nibble_serial_adder16
    import nsa_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef NSA_SUBTRACT_EN
    input  logic             Sub,
`endif
    output logic [WIDTH-1:0] Sum,
    output logic             CO,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             sub_req;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                p_grp;
    logic                g_grp;
    logic                c_next;

`ifdef NSA_SUBTRACT_EN
    assign sub_req = Sub;
`else
    assign sub_req = 1'b0;
`endif

    assign a_nib  = a_reg[int'(idx)*NIBBLE_W +: NIBBLE_W];
    assign b_nib  = b_reg[int'(idx)*NIBBLE_W +: NIBBLE_W];
    assign c_next = nibble_carry(p_grp, g_grp, carry);

    cla_slice4 u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .c_in (carry),
        .s    (s_nib),
        .p    (p_grp),
        .g    (g_grp)
    );

    // Sequencer: accept operands, step one nibble per edge, hold result until Run drops.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            Sum   <= '0;
            CO    <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        a_reg <= A;
                        // Subtraction is A + ~B + 1: invert B and seed the carry.
                        b_reg <= sub_req ? ~B : B;
                        carry <= sub_req;
                        Sum   <= '0;
                        CO    <= 1'b0;
                        idx   <= '0;
                        Busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    Sum[int'(idx)*NIBBLE_W +: NIBBLE_W] <= s_nib;
                    carry <= c_next;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        CO    <= c_next;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Run held high must not restart; require it to drop first.
                    if (!Run) begin
                        Done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder16.sv
// Self-checking bench for nibble_serial_adder16 with an expected-result scoreboard.
module tb_nibble_serial_adder16;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NIBBLES = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             co;
    } exp_t;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Run;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Sub;
    logic [WIDTH-1:0] Sum;
    logic             CO;
    logic             Busy;
    logic             Done;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    nibble_serial_adder16 #(.WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Run   (Run),
        .A     (A),
        .B     (B),
`ifdef NSA_SUBTRACT_EN
        .Sub   (Sub),
`endif
        .Sum   (Sum),
        .CO    (CO),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Drive one accept edge; optionally record the expected result.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic sub, input logic push, input logic keep_run);
        logic [WIDTH:0] full;
        exp_t e;
        A    = a;
        B    = b;
        Sub  = sub;
        full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{WIDTH{1'b0}}, sub};
        e.sum = full[WIDTH-1:0];
        e.co  = full[WIDTH];
        if (push) sb.push_back(e);
        Run = 1'b1;
        tick();
        if (!keep_run) Run = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!Done && lat < 50) begin
            tick();
            lat++;
        end
        if (!Done) check("done_timeout", 32'(Done), 32'd1);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_sum"}, 32'(Sum), 32'(e.sum));
            check({tag, "_co"}, 32'(CO), 32'(e.co));
        end
    endtask

    initial begin
        int lat;
        Reset = 1'b1;
        Run   = 1'b0;
        A     = '0;
        B     = '0;
        Sub   = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        check("rst_sum", 32'(Sum), 32'd0);
        check("rst_co", 32'(CO), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);

        // Basic add and latency.
        start_op(16'h1234, 16'h4321, 1'b0, 1'b1, 1'b0);
        check("t1_busy", 32'({Busy, Done}), 32'b10);
        wait_done(lat);
        check("t1_latency", 32'(lat), 32'(NIBBLES));
        check_result("t1");
        tick();
        check("t1_idle", 32'({Busy, Done}), 32'b00);
        check("t1_hold", 32'(Sum), 32'h5555);

        // Carry ripples through every nibble.
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0);
        wait_done(lat);
        check("t2_latency", 32'(lat), 32'(NIBBLES));
        check_result("t2");
        tick();

        // Run held high: no restart until it drops.
        start_op(16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1);
        wait_done(lat);
        check_result("t3");
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t3_hold_done", 32'({Busy, Done}), 32'b01);
        end
        Run = 1'b0;
        tick();
        check("t3_idle", 32'({Busy, Done}), 32'b00);
        check("t3_hold_co", 32'(CO), 32'd1);

        // Reset mid-ADD aborts.
        start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("t4_sum", 32'(Sum), 32'd0);
        check("t4_co", 32'(CO), 32'd0);
        check("t4_flags", 32'({Busy, Done}), 32'b00);
        tick();
        check("t4_stay_idle", 32'({Busy, Done}), 32'b00);

        // Operand change and Run pulse during ADD are ignored.
        start_op(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0);
        A   = 16'hFFFF;
        Run = 1'b1;
        tick();
        Run = 1'b0;
        wait_done(lat);
        check("t5_latency", 32'(lat), 32'(NIBBLES - 1));
        check_result("t5");
        tick();
        tick();
        check("t5_no_restart", 32'({Busy, Done}), 32'b00);

`ifdef NSA_SUBTRACT_EN
        start_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
        wait_done(lat);
        check_result("t6a");
        tick();
        start_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0);
        wait_done(lat);
        check_result("t6b");
        tick();
`endif

        // Random operands against the model.
        for (int i = 0; i < 8; i++) begin
            logic sub_r;
`ifdef NSA_SUBTRACT_EN
            sub_r = 1'($urandom_range(0, 1));
`else
            sub_r = 1'b0;
`endif
            start_op(WIDTH'($urandom), WIDTH'($urandom), sub_r, 1'b1, 1'b0);
            wait_done(lat);
            check_result("rand");
            tick();
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
